// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and constants for the pipeline hazard controller.
//   REG_ADDR_W   : register-file address width
//   STALL_CNT_W  : width of the saturating RAW stall counter
//   DRAIN_CYCLES : pipeline drain length before an interrupt is injected
//   hz_state_e   : hazard/interrupt sequencing FSM states
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int STALL_CNT_W  = 8;
  localparam int DRAIN_CYCLES = 2;

  localparam int DRAIN_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_INJECT = 2'd2,
    ST_RESUME = 2'd3
  } hz_state_e;

endpackage

// File: rtl/raw_hazard_detect.sv
// raw_hazard_detect
//   Combinational read-after-write hazard comparator for the ID stage.
//   Configuration macro: HAZ_FWD_EN
//     defined   : forwarding covers everything except load-use, so only an
//                 EX-stage scratch/IO read is a qualifying producer.
//     undefined : any EX or WB register write is a qualifying producer.
//   Ports:
//     id_rx_addr, id_ry_addr  in  source addresses of the ID instruction
//     id_use_rx, id_use_ry    in  ID instruction reads that source
//     ex_rf_wr, ex_wb_addr    in  EX writeback enable / destination
//     ex_mem_rd               in  EX result comes from a scratch/IO read
//     wb_rf_wr, wb_wb_addr    in  WB writeback enable / destination
//     raw_hit                 out ID instruction must wait
module raw_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rx_addr,
  input  logic [REG_ADDR_W-1:0] id_ry_addr,
  input  logic                  id_use_rx,
  input  logic                  id_use_ry,
  input  logic                  ex_rf_wr,
  input  logic [REG_ADDR_W-1:0] ex_wb_addr,
  input  logic                  ex_mem_rd,
  input  logic                  wb_rf_wr,
  input  logic [REG_ADDR_W-1:0] wb_wb_addr,
  output logic                  raw_hit
);

  logic rx_hit;
  logic ry_hit;

`ifdef HAZ_FWD_EN
  logic ex_qual;
  logic unused_wb;

  // WB results are always forwarded, so the WB port plays no part here.
  assign unused_wb = ^{wb_rf_wr, wb_wb_addr};
  assign ex_qual   = ex_rf_wr & ex_mem_rd;

  assign rx_hit = ex_qual & (id_rx_addr == ex_wb_addr);
  assign ry_hit = ex_qual & (id_ry_addr == ex_wb_addr);
`else
  logic unused_mem_rd;

  assign unused_mem_rd = ex_mem_rd;

  assign rx_hit = (ex_rf_wr & (id_rx_addr == ex_wb_addr)) |
                  (wb_rf_wr & (id_rx_addr == wb_wb_addr));
  assign ry_hit = (ex_rf_wr & (id_ry_addr == ex_wb_addr)) |
                  (wb_rf_wr & (id_ry_addr == wb_wb_addr));
`endif

  assign raw_hit = (id_use_rx & rx_hit) | (id_use_ry & ry_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Pipeline hazard and interrupt-entry controller. Stalls on RAW hazards,
//   flushes on taken branches and sequences interrupt entry (drain, inject,
//   resume). Strobes are combinational from the registered state and the
//   current inputs. Optional macro HAZ_FWD_EN selects the forwarding-aware
//   hazard rule inside raw_hazard_detect.
//   Ports:
//     clk, rst_n                     clock, synchronous active-low reset
//     id_rx_addr/id_ry_addr/id_use_* ID stage sources
//     ex_rf_wr/ex_wb_addr/ex_mem_rd  EX producer
//     wb_rf_wr/wb_wb_addr            WB producer
//     ex_branch_taken                branch resolved taken in EX
//     irq, i_flag                    interrupt request and enable
//     pc_stall, if_id_stall, if_id_flush, id_ex_nop, int_inject, int_ack
//                                    pipeline control strobes
//     hz_state                       FSM state (debug)
//     hz_stall_cnt                   saturating RAW stall-cycle count
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   RUN       | normal issue; RAW stalls and branch flushes handled here
//   DRAIN     | let in-flight instructions retire before the interrupt
//   INJECT    | insert the interrupt into ID/EX and acknowledge
//   RESUME    | one flush cycle while fetch redirects to the handler
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_ADDR_W-1:0]  id_rx_addr,
  input  logic [REG_ADDR_W-1:0]  id_ry_addr,
  input  logic                   id_use_rx,
  input  logic                   id_use_ry,
  input  logic                   ex_rf_wr,
  input  logic [REG_ADDR_W-1:0]  ex_wb_addr,
  input  logic                   ex_mem_rd,
  input  logic                   wb_rf_wr,
  input  logic [REG_ADDR_W-1:0]  wb_wb_addr,
  input  logic                   ex_branch_taken,
  input  logic                   irq,
  input  logic                   i_flag,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_nop,
  output logic                   int_inject,
  output logic                   int_ack,
  output logic [1:0]             hz_state,
  output logic [STALL_CNT_W-1:0] hz_stall_cnt
);

  hz_state_e              state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   raw_hit;

  raw_hazard_detect u_raw (
    .id_rx_addr (id_rx_addr),
    .id_ry_addr (id_ry_addr),
    .id_use_rx  (id_use_rx),
    .id_use_ry  (id_use_ry),
    .ex_rf_wr   (ex_rf_wr),
    .ex_wb_addr (ex_wb_addr),
    .ex_mem_rd  (ex_mem_rd),
    .wb_rf_wr   (wb_rf_wr),
    .wb_wb_addr (wb_wb_addr),
    .raw_hit    (raw_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            state <= ST_RUN;
          end else if (raw_hit) begin
            if (stall_cnt != STALL_CNT_MAX)
              stall_cnt <= stall_cnt + STALL_CNT_W'(1);
          end else if (irq && i_flag) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // A branch during drain only redirects fetch; the count runs on.
          if (drain_cnt == '0)
            state <= ST_INJECT;
          else
            drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
        end
        ST_INJECT: state <= ST_RESUME;
        ST_RESUME: state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_nop   = 1'b0;
    int_inject  = 1'b0;
    int_ack     = 1'b0;
    if (!rst_n) begin
      // Keep bubbles flowing while held in reset.
      if_id_flush = 1'b1;
      id_ex_nop   = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_nop   = 1'b1;
          end else if (raw_hit) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_nop   = 1'b1;
          end
        end
        ST_DRAIN: begin
          id_ex_nop = 1'b1;
          if (ex_branch_taken) begin
            // Let the branch target load; the wrong-path fetch is flushed.
            if_id_flush = 1'b1;
          end else begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
          end
        end
        ST_INJECT: begin
          int_inject  = 1'b1;
          int_ack     = 1'b1;
          if_id_flush = 1'b1;
        end
        ST_RESUME: if_id_flush = 1'b1;
        default: ;
      endcase
    end
  end

  assign hz_state     = state;
  assign hz_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rx_addr, id_ry_addr, ex_wb_addr, wb_wb_addr;
  logic       id_use_rx, id_use_ry, ex_rf_wr, ex_mem_rd, wb_rf_wr;
  logic       ex_branch_taken, irq, i_flag;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_nop, int_inject, int_ack;
  logic [1:0] hz_state;
  logic [7:0] hz_stall_cnt;

  // strobe vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_nop, int_inject, int_ack}
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_RSTV  = 6'b001100;
  localparam logic [5:0] S_STALL = 6'b110100;
  localparam logic [5:0] S_BR    = 6'b001100;
  localparam logic [5:0] S_INJ   = 6'b001011;
  localparam logic [5:0] S_FLUSH = 6'b001000;

  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, INJECT = 2'd2, RESUME = 2'd3;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  sc;
  logic        stim_done = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rx_addr(id_rx_addr), .id_ry_addr(id_ry_addr),
    .id_use_rx(id_use_rx), .id_use_ry(id_use_ry),
    .ex_rf_wr(ex_rf_wr), .ex_wb_addr(ex_wb_addr), .ex_mem_rd(ex_mem_rd),
    .wb_rf_wr(wb_rf_wr), .wb_wb_addr(wb_wb_addr),
    .ex_branch_taken(ex_branch_taken), .irq(irq), .i_flag(i_flag),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_nop(id_ex_nop), .int_inject(int_inject), .int_ack(int_ack),
    .hz_state(hz_state), .hz_stall_cnt(hz_stall_cnt)
  );

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [15:0] exp_v, act_v;
        string nm;
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {pc_stall, if_id_stall, if_id_flush, id_ex_nop, int_inject, int_ack,
                 hz_state, hz_stall_cnt};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL %s: strobes=%b state=%0d cnt=%0d, required strobes=%b state=%0d cnt=%0d",
                   nm, act_v[15:10], act_v[9:8], act_v[7:0],
                   exp_v[15:10], exp_v[9:8], exp_v[7:0]);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic [5:0] s, input logic [1:0] st, input logic [7:0] c);
    exp_q.push_back({s, st, c});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rx_addr = 5'd0; id_ry_addr = 5'd0; id_use_rx = 1'b0; id_use_ry = 1'b0;
    ex_rf_wr = 1'b0; ex_wb_addr = 5'd0; ex_mem_rd = 1'b0;
    wb_rf_wr = 1'b0; wb_wb_addr = 5'd0;
    ex_branch_taken = 1'b0; irq = 1'b0; i_flag = 1'b0;
  endtask

  task automatic load_use5();
    ex_rf_wr = 1'b1; ex_mem_rd = 1'b1; ex_wb_addr = 5'd5;
    id_rx_addr = 5'd5; id_use_rx = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    @(posedge clk); #1;
    cyc("reset_hold", S_RSTV, RUN, 8'd0);
    rst_n = 1'b1;
    sc = 8'd0;
    cyc("idle", S_NONE, RUN, sc);

    // load-use stall: both builds
    load_use5();
    cyc("load_use", S_STALL, RUN, sc); sc++;
    clear_in();
    cyc("after_load_use", S_NONE, RUN, sc);

    // EX ALU producer, ry match on r3
    ex_rf_wr = 1'b1; ex_mem_rd = 1'b0; ex_wb_addr = 5'd3;
    id_ry_addr = 5'd3; id_use_ry = 1'b1;
`ifdef HAZ_FWD_EN
    cyc("ex_alu_fwd", S_NONE, RUN, sc);
`else
    cyc("ex_alu_stall", S_STALL, RUN, sc); sc++;
`endif
    clear_in();
    cyc("after_ex_alu", S_NONE, RUN, sc);

    // WB producer on r7
    wb_rf_wr = 1'b1; wb_wb_addr = 5'd7; id_rx_addr = 5'd7; id_use_rx = 1'b1;
`ifdef HAZ_FWD_EN
    cyc("wb_fwd", S_NONE, RUN, sc);
`else
    cyc("wb_stall", S_STALL, RUN, sc); sc++;
`endif
    clear_in();

    // address match but source unused / producer not writing
    ex_rf_wr = 1'b1; ex_mem_rd = 1'b1; ex_wb_addr = 5'd9; id_rx_addr = 5'd9;
    cyc("match_no_use", S_NONE, RUN, sc);
    ex_rf_wr = 1'b0; id_use_rx = 1'b1;
    cyc("match_no_wr", S_NONE, RUN, sc);
    clear_in();
    irq = 1'b1; i_flag = 1'b0;
    cyc("irq_masked", S_NONE, RUN, sc);

    // full interrupt entry; irq dropped after DRAIN entry, re-raised in RESUME
    i_flag = 1'b1;
    cyc("irq_take", S_NONE, RUN, sc);
    irq = 1'b0;
    cyc("drain1", S_STALL, DRAIN, sc);
    cyc("drain2", S_STALL, DRAIN, sc);
    cyc("inject", S_INJ, INJECT, sc);
    irq = 1'b1;
    cyc("resume", S_FLUSH, RESUME, sc);
    irq = 1'b0;
    cyc("back_run", S_NONE, RUN, sc);
    cyc("no_second_ack", S_NONE, RUN, sc);

    // branch beats raw_hit and irq
    load_use5(); irq = 1'b1; i_flag = 1'b1; ex_branch_taken = 1'b1;
    cyc("branch_prio", S_BR, RUN, sc);
    clear_in();
    cyc("after_branch", S_NONE, RUN, sc);

    // reset in the INJECT cycle
    irq = 1'b1; i_flag = 1'b1;
    cyc("irq_take2", S_NONE, RUN, sc);
    irq = 1'b0;
    cyc("drain1_b", S_STALL, DRAIN, sc);
    cyc("drain2_b", S_STALL, DRAIN, sc);
    rst_n = 1'b0;
    cyc("inject_rst", S_RSTV, INJECT, sc);
    rst_n = 1'b1; sc = 8'd0;
    cyc("post_rst", S_NONE, RUN, sc);
    cyc("post_rst2", S_NONE, RUN, sc);

    // saturation over 300 stall cycles
    load_use5();
    for (int i = 0; i < 300; i++) begin
      cyc("sat_stall", S_STALL, RUN, sc);
      if (sc != 8'd255) sc++;
    end
    clear_in();
    cyc("sat_final", S_NONE, RUN, 8'd255);

    stim_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (stim_done);
        repeat (3) @(negedge clk);
      end
      begin
        repeat (2000) @(posedge clk);
        checks++; failures++;
        $display("FAIL timeout: stimulus not complete, required completion within 2000 cycles");
      end
    join_any
    disable fork;
    #1;
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
